// File: rtl/sprite_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_cmd_scheduler
//
// Queues CPU command words written over an Avalon slave port and replays them
// one per clock on the shared sprite-component command bus. Update words are
// steered into the back buffer. A commit word blocks the queue until vertical
// blank, where a single buffer-swap word is broadcast and the front buffer
// flips, so components only change ping-pong state between frames.
//
// Ports
//   clk, reset       : system clock, asynchronous active-high reset
//   chipselect       : Avalon slave select
//   write, read      : Avalon strobes, qualified by chipselect
//   address          : 0 = command FIFO, 1 = control/status
//   writedata        : Avalon write data
//   readdata         : status word (combinational) on a read of address 1, else 0
//   hcount, vcount   : pixel column / line from the VGA timing generator
//   comp_writedata   : registered command word to all components, 0 = no-op
//   front_buffer     : buffer currently being scanned out
//   swap_done        : one-cycle pulse while the swap word is on comp_writedata
// -----------------------------------------------------------------------------
module sprite_cmd_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [9:0]  VBLANK_LINE = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] comp_writedata,
  output logic        front_buffer,
  output logic        swap_done
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 32;

  localparam logic [3:0]    INFO_UPDATE  = 4'h1;
  localparam logic [3:0]    INFO_COMMIT  = 4'hF;
  localparam logic [DW-1:0] BUF_SEL_MASK = 32'h0000_2000;

  typedef enum logic [1:0] {
    ST_DRAIN   = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [DW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [DW-1:0]   r_comp_wd;
  logic            r_swap_done;
  logic            r_front;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic            w_push_req;
  logic            w_ctrl_wr;
  logic            w_status_rd;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [DW-1:0]   w_head;
  logic [3:0]      w_head_info;
  logic            w_vblank;
  state_t          w_state_next;
  logic [DW-1:0]   w_comp_next;
  logic            w_swap_next;
  logic            w_front_next;
  logic [4:0]      w_count_sat;

  // Avalon decode
  assign w_push_req  = chipselect & write & ~address;
  assign w_ctrl_wr   = chipselect & write &  address;
  assign w_status_rd = chipselect & read  &  address;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_info = w_head[20:17];
  assign w_vblank    = (vcount == VBLANK_LINE) && (hcount == 10'd0);

  // A full FIFO still takes a push when the same cycle frees a slot
  assign w_push = w_push_req & (~w_full | w_pop);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_DRAIN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state, pop control and next bus word
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_comp_next  = '0;
    w_swap_next  = 1'b0;
    w_front_next = r_front;

    case (r_state)
      ST_DRAIN: begin
        // Pop looks only at the registered count, so a same-cycle push into
        // an empty FIFO is not visible until the next cycle
        if (r_count != CW'(0)) begin
          w_pop = 1'b1;
          if (w_head_info == INFO_UPDATE) begin
            // Redirect the update into the back buffer
            w_comp_next = (w_head & ~BUF_SEL_MASK) |
                          (r_front ? '0 : BUF_SEL_MASK);
          end else if (w_head_info == INFO_COMMIT) begin
            w_state_next = ST_WAIT_VB;
          end
        end
      end

      ST_WAIT_VB: begin
        if (w_vblank) begin
          w_state_next = ST_SWAP;
          w_swap_next  = 1'b1;
          w_comp_next  = {6'h0, 5'h0, INFO_COMMIT, 3'h0, ~r_front, 13'h0};
        end
      end

      ST_SWAP: begin
        // Swap word is on the bus this cycle; flip as it leaves
        w_front_next = ~r_front;
        w_state_next = ST_DRAIN;
      end

      default: begin
        w_state_next = ST_DRAIN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_comp_wd   <= '0;
      r_swap_done <= 1'b0;
      r_front     <= 1'b0;
    end else begin
      r_comp_wd   <= w_comp_next;
      r_swap_done <= w_swap_next;
      r_front     <= w_front_next;
    end
  end

  assign comp_writedata = r_comp_wd;
  assign swap_done      = r_swap_done;
  assign front_buffer   = r_front;

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed: validity is tracked by the pointers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= writedata;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared by control write bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ctrl_wr && writedata[0]) begin
      r_overflow <= 1'b0;
    end else if (w_push_req && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status readback
  // ---------------------------------------------------------------------------
  always_comb begin
    if (32'(r_count) > 32'd31) begin
      w_count_sat = 5'd31;
    end else begin
      w_count_sat = 5'(r_count);
    end
  end

  assign readdata = w_status_rd ?
                    {21'h0, (r_state == ST_WAIT_VB), r_overflow, r_front,
                     3'h0, w_count_sat} :
                    32'h0;

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sprite_cmd_scheduler
//
// Directed scenarios followed by randomized bus traffic. A queue-based
// reference model tracks the command stream, buffer state and status word.
// -----------------------------------------------------------------------------
module tb_sprite_cmd_scheduler;

  localparam int unsigned DEPTH = 16;
  localparam logic [9:0]  VB    = 10'd480;
  localparam logic [9:0]  V_LO  = 10'd476;
  localparam logic [9:0]  V_HI  = 10'd483;
  localparam logic [9:0]  H_MAX = 10'd7;
  localparam logic [31:0] COMMIT_WORD = 32'h001E_0000;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        wr;
  logic        rd;
  logic        addr;
  logic [31:0] wd;
  logic [31:0] readdata;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [31:0] comp_writedata;
  logic        front_buffer;
  logic        swap_done;

  sprite_cmd_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .VBLANK_LINE (VB)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .chipselect     (cs),
    .write          (wr),
    .read           (rd),
    .address        (addr),
    .writedata      (wd),
    .readdata       (readdata),
    .hcount         (hc),
    .vcount         (vc),
    .comp_writedata (comp_writedata),
    .front_buffer   (front_buffer),
    .swap_done      (swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the pending commands are a plain queue; "blocked" means a
  // commit has been consumed and the swap has not yet been broadcast.
  // ---------------------------------------------------------------------------
  logic [31:0] mq[$];
  bit          m_front;
  bit          m_ovf;
  bit          m_blocked;
  bit          m_swap_now;
  logic [31:0] exp_comp;
  bit          exp_swap;

  function automatic void model_reset();
    mq.delete();
    m_front    = 1'b0;
    m_ovf      = 1'b0;
    m_blocked  = 1'b0;
    m_swap_now = 1'b0;
    exp_comp   = 32'h0;
    exp_swap   = 1'b0;
  endfunction

  function automatic logic [31:0] model_status();
    logic [4:0] cnt;
    cnt = (mq.size() > 31) ? 5'd31 : 5'(mq.size());
    return {21'h0, m_blocked, m_ovf, m_front, 3'h0, cnt};
  endfunction

  // One clock edge of the model, using the inputs present before the edge
  function automatic void model_step();
    logic [31:0] w;
    logic [31:0] nc;
    bit          ns;
    bit          commit;
    bit          vb;
    bit          can_pop;
    if (reset) begin
      model_reset();
      return;
    end
    nc      = 32'h0;
    ns      = 1'b0;
    commit  = 1'b0;
    vb      = (vc == VB) && (hc == 10'd0);
    can_pop = !m_blocked && !m_swap_now && (mq.size() > 0);
    if (m_blocked && vb) begin
      nc = 32'h001E_0000 | (m_front ? 32'h0 : 32'h0000_2000);
      ns = 1'b1;
    end
    if (can_pop) begin
      w = mq.pop_front();
      if (w[20:17] == 4'h1) begin
        w[13] = ~m_front;
        nc    = w;
      end else if (w[20:17] == 4'hF) begin
        commit = 1'b1;
      end
    end
    if (cs && wr && !addr) begin
      if (mq.size() < DEPTH) mq.push_back(wd);
      else m_ovf = 1'b1;
    end
    if (cs && wr && addr && wd[0]) m_ovf = 1'b0;
    if (m_swap_now) m_front = ~m_front;
    m_blocked  = commit ? 1'b1 : (m_blocked && !vb);
    m_swap_now = ns;
    exp_comp   = nc;
    exp_swap   = ns;
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle helpers
  // ---------------------------------------------------------------------------
  logic [31:0] obs_comp;
  logic        obs_swap;
  logic [9:0]  obs_v;
  logic [9:0]  obs_h;
  logic [31:0] obs_rd;
  int          n_swaps   = 0;
  int          n_nonzero = 0;

  task automatic idle_bus();
    cs   = 1'b0;
    wr   = 1'b0;
    rd   = 1'b0;
    addr = 1'b0;
    wd   = 32'h0;
  endtask

  task automatic set_video(input logic [9:0] v, input logic [9:0] h);
    vc = v;
    hc = h;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    obs_comp = comp_writedata;
    obs_swap = swap_done;
    obs_v    = vc;
    obs_h    = hc;
    check_eq("comp_writedata", comp_writedata, exp_comp);
    check_eq("swap_done", 32'(swap_done), 32'(exp_swap));
    check_eq("front_buffer", 32'(front_buffer), 32'(m_front));
    if (swap_done === 1'b1) n_swaps++;
    if (comp_writedata !== 32'h0) n_nonzero++;
    @(negedge clk);
    if (hc == H_MAX) begin
      hc = 10'd0;
      vc = (vc >= V_HI) ? V_LO : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end
    idle_bus();
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    cs   = 1'b1;
    wr   = 1'b1;
    addr = a;
    wd   = d;
    tick();
  endtask

  task automatic bus_read(input logic a);
    cs   = 1'b1;
    rd   = 1'b1;
    addr = a;
    #1;
    obs_rd = readdata;
    check_eq("readdata", readdata, a ? model_status() : 32'h0);
    tick();
  endtask

  task automatic wait_swap(input int max_cycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (obs_swap === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic async_reset_check(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_eq({tag, "_comp"}, comp_writedata, 32'h0);
    check_eq({tag, "_swap"}, 32'(swap_done), 32'h0);
    check_eq({tag, "_front"}, 32'(front_buffer), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    int n0;
    int s0;
    logic [31:0] word;

    reset = 1'b1;
    idle_bus();
    set_video(10'd100, 10'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    bus_read(1'b1);
    check_eq("reset_status", obs_rd, 32'h0);

    // Single update lands in the back buffer
    bus_write(1'b0, 32'h3C02_5000);
    tick();
    check_eq("t1_word", obs_comp, 32'h3C02_7000);
    tick();
    check_eq("t1_idle", obs_comp, 32'h0);

    // Three updates and a commit, swap at vblank
    set_video(10'd100, 10'd0);
    bus_write(1'b0, 32'h0802_0005);
    bus_write(1'b0, 32'h0402_1234);
    bus_write(1'b0, 32'h0C02_0123);
    bus_write(1'b0, COMMIT_WORD);
    check_eq("t2_third", obs_comp, 32'h0C02_2123);
    wait_swap(4000, found);
    check_eq("t2_swap_found", 32'(found), 32'h1);
    check_eq("t2_swap_word", obs_comp, 32'h001E_2000);
    check_eq("t2_swap_pos", {22'h0, obs_v}, {22'h0, VB});
    check_eq("t2_swap_hpos", {22'h0, obs_h}, 32'h0);

    // Update after the swap targets buffer 0
    bus_write(1'b0, 32'h0402_2001);
    check_eq("t3_front", 32'(front_buffer), 32'h1);
    tick();
    check_eq("t3_word", obs_comp, 32'h0402_0001);

    // Overflow behind a leading commit
    set_video(10'd100, 10'd0);
    bus_write(1'b0, COMMIT_WORD);
    for (int i = 0; i < 17; i++) begin
      word = {6'(i + 1), 5'h0, 4'h1, 3'h1, 1'b0, 13'(i)};
      bus_write(1'b0, word);
    end
    bus_read(1'b1);
    check_eq("t4_status_full", obs_rd, 32'h0000_0710);
    bus_write(1'b1, 32'h1);
    bus_read(1'b1);
    check_eq("t4_status_clr", obs_rd, 32'h0000_0510);
    n0 = n_nonzero;
    wait_swap(5000, found);
    check_eq("t4_swap_found", 32'(found), 32'h1);
    repeat (20) tick();
    check_eq("t4_drained", 32'(n_nonzero - n0), 32'd17);

    // Commit popped exactly on the vblank cycle waits a whole frame
    set_video(10'd479, H_MAX);
    bus_write(1'b0, COMMIT_WORD);
    s0 = n_swaps;
    repeat (60) tick();
    check_eq("t5_no_early_swap", 32'(n_swaps - s0), 32'h0);
    wait_swap(20, found);
    check_eq("t5_next_frame_swap", 32'(found), 32'h1);

    // Reset while blocked with words queued
    set_video(10'd100, 10'd0);
    bus_write(1'b0, COMMIT_WORD);
    for (int i = 0; i < 5; i++) bus_write(1'b0, 32'h0402_0000 | 32'(i));
    repeat (2) tick();
    async_reset_check("t6_reset");
    cs   = 1'b1;
    rd   = 1'b1;
    addr = 1'b1;
    #1;
    check_eq("t6_status", readdata, 32'h0);
    tick();
    reset = 1'b0;
    n0 = n_nonzero;
    repeat (100) tick();
    check_eq("t6_silent", 32'(n_nonzero - n0), 32'h0);

    // Randomized traffic against the model
    set_video(V_LO, 10'd0);
    for (int c = 0; c < 3000; c++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        async_reset_check("rnd_reset");
        tick();
        reset = 1'b0;
      end else if (r < 45) begin
        k    = $urandom_range(0, 19);
        word = $urandom;
        if (k < 10)      word[20:17] = 4'h1;
        else if (k < 12) word[20:17] = 4'hF;
        bus_write(1'b0, word);
      end else if (r < 60) begin
        bus_read(1'($urandom_range(0, 1)));
      end else if (r < 65) begin
        bus_write(1'b1, $urandom);
      end else begin
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
